dac_frame_serializer: RTL
=========================

DAC_FRAME_SERIALIZER -- requirements
Module: dac_frame_serializer

Interface
REQ-001 Parameter NUM_CH, default 2, channels per frame (legal 1..4).
REQ-002 Parameter SAMPLE_W, default 16, bits per sample (legal 8..16, even).
REQ-003 Parameter FILL_HOLD, default 0; on underrun, 0 outputs zero samples and 1 re-outputs the last frame.
REQ-004 Parameter FRAME_PULSE, default 0; 0 toggles frame once per frame, 1 drives frame high during slot 0 only.
REQ-005 clk_dac0  in  1  DAC data clock; all logic is on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  requests streaming; sampled only at frame boundaries.
REQ-008 mode  in  2  source select: 0 FIFO, 1 zero, 2 ramp, 3 constant test_word.
REQ-009 test_word  in  SAMPLE_W  constant pattern used in mode 3.
REQ-010 clr_status  in  1  one-cycle pulse that clears underrun status.
REQ-011 fifo_dout  in  NUM_CH*SAMPLE_W  first-word-fall-through FIFO data; channel 0 is the MS slice.
REQ-012 fifo_empty  in  1  FIFO empty flag.
REQ-013 fifo_rd_en  out  1  FIFO pop strobe, combinational.
REQ-014 data_out  out  SAMPLE_W  sample for the current slot, registered, feeds the DDR output stage.
REQ-015 frame  out  1  frame marker, registered, aligned with data_out.
REQ-016 active  out  1  high while in RUN.
REQ-017 underrun  out  1  sticky flag: a frame boundary found the FIFO empty.
REQ-018 underrun_cnt  out  16  saturating count of underrun frames.

Function
REQ-019 The slot counter counts 0..NUM_CH-1 and wraps; a frame boundary is any edge where slot==NUM_CH-1.
REQ-020 The FSM has three states: IDLE, PRIME and RUN.
REQ-021 IDLE: data_out=0, frame=0, slot held at 0; go to PRIME when enable=1.
REQ-022 PRIME: wait until fifo_empty=0 (mode 0) or for one cycle (modes 1-3), load the shadow frame, then go to RUN with slot=0.
REQ-023 RUN: at each frame boundary, if enable=0 go to IDLE after the last slot is output, otherwise load the next shadow frame.
REQ-024 fifo_rd_en = (state==RUN at a frame boundary, or PRIME load) AND mode==0 AND fifo_empty==0.
REQ-025 At most one pop per frame; the FIFO is never read outside mode 0.
REQ-026 A word popped at edge E appears on data_out as ch0..chN-1 on cycles E+1..E+NUM_CH (latency 1).
REQ-027 Underrun occurs when RUN, mode 0, at a frame boundary, and fifo_empty=1: no pop; the shadow is zeroed (FILL_HOLD=0) or kept (FILL_HOLD=1).
REQ-028 On underrun, underrun is set and underrun_cnt increments, saturating at 0xFFFF.
REQ-029 Underrun and clr_status in the same cycle: the set wins and the count becomes 1.
REQ-030 Ramp mode: a SAMPLE_W counter increments once per frame and wraps; channel k = ramp+k modulo 2^SAMPLE_W.
REQ-031 A mode change takes effect only at the next frame boundary; mid-frame samples are unaffected.
REQ-032 FRAME_PULSE=0: frame inverts with the slot-0 sample of every frame; the first frame after IDLE drives frame=1.
REQ-033 FRAME_PULSE=1: frame=1 exactly while data_out carries channel 0.
REQ-034 NUM_CH=1: every cycle is a frame boundary; one pop per cycle is permitted.

Reset
REQ-035 Reset returns the FSM to IDLE and clears slot, shadow, ramp, data_out, frame, active, underrun and underrun_cnt; fifo_rd_en=0 while reset=1.
REQ-036 Reset mid-frame aborts the frame without a pop; the next data_out is 0.

Structure
REQ-037 A shared package dac_pkg holds the mode encoding constants and the FSM state type.
REQ-038 Sub-module dac_test_pattern generates the zero, ramp and constant frames; the FIFO path stays in the top.

Verification
REQ-039 NUM_CH=2, FIFO preloaded 0x1111_2222, 0x3333_4444, enable=1 -> data_out 1111,2222,3333,4444; frame toggles 1,1,0,0.
REQ-040 NUM_CH=2, FILL_HOLD=0, FIFO empties after one word -> 0000,0000 frames follow; underrun=1; underrun_cnt increments once per empty frame.
REQ-041 FILL_HOLD=1, same stimulus -> the last frame repeats; no fifo_rd_en while empty.
REQ-042 Mode 2, NUM_CH=4 -> frames (0,1,2,3), (1,2,3,4), ...; wraps correctly at 0xFFFF.
REQ-043 enable drops mid-frame -> the current frame completes, then IDLE with data_out=0 and active=0.
REQ-044 reset asserted at slot 1 -> the next cycle data_out=0, frame=0, underrun_cnt=0, and no pop.

Source files
------------

// File: rtl/dac_pkg.sv
// dac_pkg: mode encoding and FSM state type shared by the DAC frame serializer.
package dac_pkg;
    localparam logic [1:0] MODE_FIFO  = 2'd0;
    localparam logic [1:0] MODE_ZERO  = 2'd1;
    localparam logic [1:0] MODE_RAMP  = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;
    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
endpackage

// File: rtl/dac_test_pattern.sv
// dac_test_pattern: zero, ramp and constant frames; the ramp advances once per loaded ramp frame.
module dac_test_pattern
    import dac_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 16
) (
    input  logic                         clk_dac0,
    input  logic                         reset,
    input  logic                         advance,
    input  logic [1:0]                   mode,
    input  logic [SAMPLE_W-1:0]          test_word,
    output logic [NUM_CH*SAMPLE_W-1:0]   pattern
);
    logic [SAMPLE_W-1:0] ramp;
    always_ff @(posedge clk_dac0) ramp <= reset ? '0 : ramp + SAMPLE_W'(advance);
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign pattern[(NUM_CH-1-c)*SAMPLE_W +: SAMPLE_W] =
            mode == MODE_RAMP ? ramp + SAMPLE_W'(c) : mode == MODE_CONST ? test_word : '0;
    end
endmodule

// File: rtl/dac_frame_serializer.sv
// dac_frame_serializer: serializes FIFO or test-pattern frames into one registered DAC sample per slot.
module dac_frame_serializer
    import dac_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int SAMPLE_W    = 16,
    parameter int FILL_HOLD   = 0,
    parameter int FRAME_PULSE = 0
) (
    input  logic                       clk_dac0,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [1:0]                 mode,
    input  logic [SAMPLE_W-1:0]        test_word,
    input  logic                       clr_status,
    input  logic [NUM_CH*SAMPLE_W-1:0] fifo_dout,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    output logic [SAMPLE_W-1:0]        data_out,
    output logic                       frame,
    output logic                       active,
    output logic                       underrun,
    output logic [15:0]                underrun_cnt
);
    localparam int FW = NUM_CH * SAMPLE_W;
    localparam int SW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    state_t state;
    logic [SW-1:0] slot;
    logic [FW-1:0] shadow, pattern, src;
    logic boundary, fifo_mode, run_load, load, underrun_hit;
    logic [SAMPLE_W-1:0] next_sample;

    // data_out already shows the slot held in 'slot'; a boundary edge presents slot 0 of the next frame
    always_comb begin
        boundary = slot == SW'(NUM_CH - 1);
        fifo_mode = mode == MODE_FIFO;
        run_load = state == RUN && boundary && enable;
        load = run_load || (state == PRIME && (!fifo_mode || !fifo_empty));
        underrun_hit = run_load && fifo_mode && fifo_empty;
        fifo_rd_en = !reset && load && fifo_mode && !fifo_empty;
        src = !fifo_mode ? pattern : !fifo_empty ? fifo_dout : FILL_HOLD != 0 ? shadow : '0;
        next_sample = shadow[(NUM_CH - 2 - int'(slot)) * SAMPLE_W +: SAMPLE_W];
    end

    dac_test_pattern #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W)) u_pattern (
        .clk_dac0(clk_dac0),
        .reset(reset),
        .advance(load && mode == MODE_RAMP),
        .mode(mode),
        .test_word(test_word),
        .pattern(pattern)
    );

    always_ff @(posedge clk_dac0) begin
        if (reset) begin
            state <= IDLE;
            slot <= '0;
            shadow <= '0;
            data_out <= '0;
            frame <= 1'b0;
            active <= 1'b0;
            underrun <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= underrun_hit || (underrun && !clr_status);
            underrun_cnt <= underrun_hit ? (clr_status ? 16'd1 : underrun_cnt + 16'(underrun_cnt != 16'hFFFF))
                          : clr_status ? 16'd0 : underrun_cnt;
            if (load) begin
                state <= RUN;
                active <= 1'b1;
                slot <= '0;
                shadow <= src;
                data_out <= src[FW-1 -: SAMPLE_W];
                frame <= FRAME_PULSE != 0 ? 1'b1 : !frame;
            end else if (state == RUN && !boundary) begin
                slot <= slot + SW'(1);
                data_out <= next_sample;
                frame <= FRAME_PULSE != 0 ? 1'b0 : frame;
            end else if (state == IDLE || !enable) begin
                state <= state == IDLE && enable ? PRIME : IDLE;
                active <= 1'b0;
                slot <= '0;
                data_out <= '0;
                frame <= 1'b0;
            end
        end
    end
endmodule
